// File: rtl/comparador_serial.sv
// comparador_serial: multi-cycle MSB-first magnitude comparator with 7485-style cascade inputs.
// Optional macro COMPARADOR_SERIAL_EARLY_EXIT_EN ends the compare at the first unequal slice.
`default_nettype none

module comparador_serial #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ALBi,
  input  logic             AGBi,
  input  logic             AEBi,
  output logic             ocupado,
  output logic             pronto,
  output logic             ALBo,
  output logic             AGBo,
  output logic             AEBo
);

  localparam int NSLICES = (WIDTH + SLICE - 1) / SLICE;
  localparam int PADW    = NSLICES * SLICE;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;

`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PADW-1:0]   r_a;
  logic [PADW-1:0]   r_b;
  logic              r_lbi;
  logic              r_gbi;
  logic              r_ebi;
  logic [IDXW-1:0]   r_idx;
  logic              r_decidido;
  logic [SLICE-1:0]  w_a_sl;
  logic [SLICE-1:0]  w_b_sl;
  logic              w_gt;
  logic              w_lt;
  logic              w_last;
  logic              w_start;

  assign w_a_sl  = r_a[r_idx*SLICE +: SLICE];
  assign w_b_sl  = r_b[r_idx*SLICE +: SLICE];
  assign w_gt    = (w_a_sl > w_b_sl);
  assign w_lt    = (w_a_sl < w_b_sl);
  assign w_last  = (r_idx == '0);
  assign w_start = iniciar && (r_state != COMPARA);

  assign ocupado = (r_state == COMPARA);
  assign pronto  = (r_state == FIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= OCIOSO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      OCIOSO:  if (iniciar) w_next = COMPARA;
      COMPARA: if (w_last || (EARLY_EXIT && (w_gt || w_lt))) w_next = FIM;
      FIM:     w_next = iniciar ? COMPARA : OCIOSO;
      default: w_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_lbi      <= 1'b0;
      r_gbi      <= 1'b0;
      r_ebi      <= 1'b0;
      r_idx      <= '0;
      r_decidido <= 1'b0;
      ALBo       <= 1'b0;
      AGBo       <= 1'b0;
      AEBo       <= 1'b0;
    end else if (w_start) begin
      r_a        <= PADW'(A);
      r_b        <= PADW'(B);
      r_lbi      <= ALBi;
      r_gbi      <= AGBi;
      r_ebi      <= AEBi;
      r_idx      <= IDXW'(NSLICES - 1);
      r_decidido <= 1'b0;
      ALBo       <= 1'b0;
      AGBo       <= 1'b0;
      AEBo       <= 1'b0;
    end else if (r_state == COMPARA) begin
      // Once decided, remaining slices are only stepped through (constant-latency build).
      if (!r_decidido) begin
        if (w_gt) begin
          AGBo       <= 1'b1;
          ALBo       <= 1'b0;
          AEBo       <= 1'b0;
          r_decidido <= 1'b1;
        end else if (w_lt) begin
          ALBo       <= 1'b1;
          AGBo       <= 1'b0;
          AEBo       <= 1'b0;
          r_decidido <= 1'b1;
        end else if (w_last) begin
          ALBo <= r_lbi;
          AGBo <= r_gbi;
          AEBo <= r_ebi;
        end
      end
      if (!w_last) r_idx <= r_idx - 1'b1;
    end
  end

endmodule

`default_nettype wire
